// File: rtl/uart_rx_fsm.sv
// UART receiver: oversampled start detection with glitch rejection, LSB-first
// deserialisation, and a one-cycle valid or framing-error pulse per frame.
module uart_rx_fsm #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 framing_error,
  output logic                 busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);

  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state, state_next;
  logic                 rx_meta, rx_s;
  logic [TICK_W-1:0]    tick_cnt, tick_next;
  logic [BIT_W-1:0]     bit_cnt, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [DATA_BITS-1:0] data_next;
  logic                 valid_next, ferr_next, busy_next;

  // rx is asynchronous, so it is synchronised on every clk regardless of sample_tick
  always_ff @(posedge clk) begin
    if (rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state         <= IDLE;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_next;
      tick_cnt      <= tick_next;
      bit_cnt       <= bit_next;
      shift_reg     <= shift_next;
      data_out      <= data_next;
      data_valid    <= valid_next;
      framing_error <= ferr_next;
      busy          <= busy_next;
    end
  end

  // Leaving STOP at mid stop bit lets a following start edge be caught with no idle gap
  always_comb begin
    state_next = state;
    tick_next  = tick_cnt;
    bit_next   = bit_cnt;
    shift_next = shift_reg;
    data_next  = data_out;
    valid_next = 1'b0;
    ferr_next  = 1'b0;

    case (state)
      IDLE: begin
        if (sample_tick && !rx_s) begin
          state_next = START;
          tick_next  = '0;
        end
      end
      START: begin
        if (sample_tick) begin
          tick_next = tick_cnt + 1'b1;
          if (tick_cnt == HALF_LAST) begin
            if (!rx_s) begin
              state_next = DATA;
              tick_next  = '0;
              bit_next   = '0;
            end else begin
              state_next = IDLE;
            end
          end
        end
      end
      DATA: begin
        if (sample_tick) begin
          tick_next = tick_cnt + 1'b1;
          if (tick_cnt == FULL_LAST) begin
            shift_next = {rx_s, shift_reg[DATA_BITS-1:1]};
            tick_next  = '0;
            if (bit_cnt == BIT_LAST) begin
              state_next = STOP;
            end else begin
              bit_next = bit_cnt + 1'b1;
            end
          end
        end
      end
      STOP: begin
        if (sample_tick) begin
          tick_next = tick_cnt + 1'b1;
          if (tick_cnt == FULL_LAST) begin
            state_next = IDLE;
            if (rx_s) begin
              data_next  = shift_reg;
              valid_next = 1'b1;
            end else begin
              ferr_next = 1'b1;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Scoreboard bench for uart_rx_fsm: directed frames push expected results,
// a forked monitor pops and compares on every data_valid/framing_error pulse.
module tb_uart_rx_fsm;

  localparam int BIT_CLKS = 64;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       sample_tick;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       framing_error;
  logic       busy;

  exp_t exp_q[$];
  int   checks;
  int   fails;
  int   busy_total;
  int   tick_div;

  uart_rx_fsm #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sample_tick(sample_tick),
    .rx(rx),
    .data_out(data_out),
    .data_valid(data_valid),
    .framing_error(framing_error),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One sample_tick every 4 clk gives 16 ticks per 64-clk bit period
  initial begin
    sample_tick = 1'b0;
    tick_div    = 0;
    forever begin
      @(negedge clk);
      tick_div    = (tick_div == 3) ? 0 : tick_div + 1;
      sample_tick = (tick_div == 0);
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy) busy_total++;
      if (data_valid || framing_error) begin
        check_output("pulse_exclusive", {31'd0, data_valid && framing_error}, 32'd0);
        if (exp_q.size() == 0) begin
          check_output("unexpected_pulse", {30'd0, data_valid, framing_error}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_output("pulse_kind", {31'd0, framing_error}, {31'd0, e.is_err});
          check_output("data_out", {24'd0, data_out}, {24'd0, e.data});
        end
      end
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * BIT_CLKS) @(negedge clk);
  endtask

  // held is the data_out value expected alongside a framing error
  task automatic apply_stimulus(input logic [7:0] d, input logic stop_bit,
                                input logic [7:0] held);
    exp_t e;
    e.is_err = ~stop_bit;
    e.data   = stop_bit ? d : held;
    exp_q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_bit);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_output(name, exp_q.size(), 32'd0);
  endtask

  initial begin
    int b0;
    checks = 0;
    fails  = 0;
    busy_total = 0;
    rx    = 1'b1;
    rst_n = 1'b1;
    fork
      monitor();
    join_none

    // Reset held while the line toggles
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      check_output("reset_data_out", {24'd0, data_out}, 32'd0);
      check_output("reset_valid", {31'd0, data_valid}, 32'd0);
      check_output("reset_ferr", {31'd0, framing_error}, 32'd0);
      check_output("reset_busy", {31'd0, busy}, 32'd0);
      rx = ~rx;
    end
    rx    = 1'b1;
    rst_n = 1'b0;
    idle_bits(1);

    $display("[TB] single byte 0xA5");
    b0 = busy_total;
    apply_stimulus(8'hA5, 1'b1, 8'h00);
    idle_bits(1);
    wait_drain("drain_single");
    check_output("busy_len_single",
                 {31'd0, (busy_total - b0 >= 604) && (busy_total - b0 <= 612)}, 32'd1);

    $display("[TB] back-to-back 0x00 0xFF 0x3C");
    apply_stimulus(8'h00, 1'b1, 8'h00);
    apply_stimulus(8'hFF, 1'b1, 8'h00);
    apply_stimulus(8'h3C, 1'b1, 8'h00);
    idle_bits(2);
    wait_drain("drain_b2b");

    $display("[TB] glitch start bit");
    b0 = busy_total;
    rx = 1'b0;
    repeat (12) @(negedge clk);
    idle_bits(3);
    check_output("busy_len_glitch",
                 {31'd0, (busy_total - b0 >= 1) && (busy_total - b0 <= 32)}, 32'd1);
    check_output("glitch_busy_idle", {31'd0, busy}, 32'd0);

    $display("[TB] framing error on 0x55");
    apply_stimulus(8'h55, 1'b0, 8'h3C);
    idle_bits(2);
    wait_drain("drain_ferr");
    check_output("ferr_data_held", {24'd0, data_out}, 32'h3C);

    $display("[TB] reset during data bit 4 of 0x81");
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h81 >> i));
    rx = 1'b0;
    repeat (32) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_output("midreset_busy", {31'd0, busy}, 32'd0);
    check_output("midreset_data_out", {24'd0, data_out}, 32'd0);
    rst_n = 1'b0;
    idle_bits(2);
    apply_stimulus(8'h42, 1'b1, 8'h00);
    idle_bits(1);
    wait_drain("drain_after_reset");
    check_output("final_data_out", {24'd0, data_out}, 32'h42);
    check_output("final_busy", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
